// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC command sequencer.
// Holds the init-sequence states, command tags and the decode bit positions.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    localparam logic CMD_ICW = 1'b1;
    localparam logic CMD_OCW = 1'b0;

    localparam logic [1:0] ICW1_NR = 2'd0;
    localparam logic [1:0] ICW2_NR = 2'd1;
    localparam logic [1:0] ICW3_NR = 2'd2;
    localparam logic [1:0] ICW4_NR = 2'd3;
    localparam logic [1:0] OCW1_NR = 2'd0;
    localparam logic [1:0] OCW2_NR = 2'd1;
    localparam logic [1:0] OCW3_NR = 2'd2;

    localparam int IC4     = 0;
    localparam int SNGL    = 1;
    localparam int ICW1_ID = 4;
    localparam int OCW3_ID = 3;
    localparam int RR      = 1;
    localparam int RIS     = 0;

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// CPU-side pins, register read-back inputs and the command output bundle of the sequencer.
// master drives the CPU pins and register values; slave is the sequencer itself.
interface pic_cmd_sequencer_if #(parameter int DATA_W = 8);

    logic              cs_n;
    logic              wr_n;
    logic              rd_n;
    logic              a0;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] irr;
    logic [DATA_W-1:0] isr;
    logic [DATA_W-1:0] imr;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;
    logic              cmd_valid;
    logic              cmd_type;
    logic [1:0]        cmd_nr;
    logic [DATA_W-1:0] cmd_data;
    logic              init_done;
    logic              seq_err;

    modport master (
        output cs_n, wr_n, rd_n, a0, d_in, irr, isr, imr,
        input  d_out, d_oe, cmd_valid, cmd_type, cmd_nr, cmd_data, init_done, seq_err
    );

    modport slave (
        input  cs_n, wr_n, rd_n, a0, d_in, irr, isr, imr,
        output d_out, d_oe, cmd_valid, cmd_type, cmd_nr, cmd_data, init_done, seq_err
    );

endinterface

// File: rtl/pic_strobe_sync.sv
// Multi-stage synchroniser for one CPU strobe, with a rising-edge flag one cycle wide.
// Latency SYNC_STAGES cycles to sync, rise valid in the following cycle; no backpressure.
module pic_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   last;

    // Idle-high reset so a strobe held high across reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '1;
            last   <= 1'b1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], pin};
            last   <= stages[SYNC_STAGES-1];
        end
    end

    assign sync = stages[SYNC_STAGES-1];
    assign rise = sync & ~last;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// Synchronises CPU strobes, walks the ICW1..ICW4 init sequence and issues tagged command pulses.
// Writes and reads appear SYNC_STAGES+1 cycles after the pin edge; no backpressure, bad writes pulse seq_err.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit CASCADE_EN  = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    pic_cmd_sequencer_if.slave bus
);

    logic cs_s, wr_s, rd_s, a0_s;
    logic cs_rise, wr_rise, rd_rise, a0_rise;
    logic unused_rise;

    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .pin(bus.cs_n), .sync(cs_s), .rise(cs_rise));
    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clk(clk), .rst_n(rst_n), .pin(bus.wr_n), .sync(wr_s), .rise(wr_rise));
    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .clk(clk), .rst_n(rst_n), .pin(bus.rd_n), .sync(rd_s), .rise(rd_rise));
    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_a0_sync (
        .clk(clk), .rst_n(rst_n), .pin(bus.a0), .sync(a0_s), .rise(a0_rise));

    assign unused_rise = &{1'b0, cs_rise, rd_rise, a0_rise};

    logic              cs_cap;
    logic              a0_cap;
    logic [DATA_W-1:0] d_cap;
    logic              wr_evt;

    // cs_n is tracked for the whole low phase of wr_n so the event knows if it was selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_cap <= 1'b1;
            a0_cap <= 1'b0;
            d_cap  <= '0;
        end else if (!wr_s) begin
            cs_cap <= cs_s;
            if (!cs_s) begin
                a0_cap <= a0_s;
                d_cap  <= bus.d_in;
            end
        end
    end

    assign wr_evt = wr_rise & ~cs_cap;

    state_t     state, nxt_state;
    logic       ic4, sngl, rd_sel;
    logic       issue, issue_type, drop, cfg_we, sel_we, sel_nxt;
    logic [1:0] issue_nr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UNINIT;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state  = state;
        issue      = 1'b0;
        issue_type = CMD_OCW;
        issue_nr   = OCW1_NR;
        drop       = 1'b0;
        cfg_we     = 1'b0;
        sel_we     = 1'b0;
        sel_nxt    = rd_sel;
        if (wr_evt) begin
            if (!a0_cap && d_cap[ICW1_ID]) begin
                nxt_state  = WAIT_ICW2;
                issue      = 1'b1;
                issue_type = CMD_ICW;
                issue_nr   = ICW1_NR;
                cfg_we     = 1'b1;
                sel_we     = 1'b1;
                sel_nxt    = 1'b0;
            end else begin
                case (state)
                    WAIT_ICW2: begin
                        if (a0_cap) begin
                            issue      = 1'b1;
                            issue_type = CMD_ICW;
                            issue_nr   = ICW2_NR;
                            if (!sngl && CASCADE_EN) nxt_state = WAIT_ICW3;
                            else if (ic4)            nxt_state = WAIT_ICW4;
                            else                     nxt_state = READY;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    WAIT_ICW3: begin
                        if (a0_cap) begin
                            issue      = 1'b1;
                            issue_type = CMD_ICW;
                            issue_nr   = ICW3_NR;
                            nxt_state  = ic4 ? WAIT_ICW4 : READY;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    WAIT_ICW4: begin
                        if (a0_cap) begin
                            issue      = 1'b1;
                            issue_type = CMD_ICW;
                            issue_nr   = ICW4_NR;
                            nxt_state  = READY;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    READY: begin
                        issue = 1'b1;
                        if (a0_cap) begin
                            issue_nr = OCW1_NR;
                        end else if (!d_cap[OCW3_ID]) begin
                            issue_nr = OCW2_NR;
                        end else begin
                            issue_nr = OCW3_NR;
                            if (d_cap[RR]) begin
                                sel_we  = 1'b1;
                                sel_nxt = d_cap[RIS];
                            end
                        end
                    end
                    default: drop = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd_valid <= 1'b0;
            bus.cmd_type  <= 1'b0;
            bus.cmd_nr    <= 2'd0;
            bus.cmd_data  <= '0;
            bus.seq_err   <= 1'b0;
            ic4           <= 1'b0;
            sngl          <= 1'b0;
            rd_sel        <= 1'b0;
        end else begin
            bus.cmd_valid <= issue;
            bus.seq_err   <= drop;
            if (issue) begin
                bus.cmd_type <= issue_type;
                bus.cmd_nr   <= issue_nr;
                bus.cmd_data <= d_cap;
            end
            if (cfg_we) begin
                ic4  <= d_cap[IC4];
                sngl <= d_cap[SNGL];
            end
            if (sel_we) rd_sel <= sel_nxt;
        end
    end

    logic rd_en;
    // A write in progress (wr_n low) always wins the bus over a read.
    assign rd_en = !cs_s && !rd_s && wr_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.d_oe  <= 1'b0;
            bus.d_out <= '0;
        end else begin
            bus.d_oe  <= rd_en;
            bus.d_out <= !rd_en ? '0 : a0_s ? bus.imr : rd_sel ? bus.isr : bus.irr;
        end
    end

    assign bus.init_done = (state == READY);

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench: two sequencers (cascade on/off) share one CPU stimulus stream.
module tb_pic_cmd_sequencer;

    localparam int S = 2;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    pic_cmd_sequencer_if #(.DATA_W(8)) bus ();
    pic_cmd_sequencer_if #(.DATA_W(8)) bus_b ();

    assign bus_b.cs_n = bus.cs_n;
    assign bus_b.wr_n = bus.wr_n;
    assign bus_b.rd_n = bus.rd_n;
    assign bus_b.a0   = bus.a0;
    assign bus_b.d_in = bus.d_in;
    assign bus_b.irr  = bus.irr;
    assign bus_b.isr  = bus.isr;
    assign bus_b.imr  = bus.imr;

    pic_cmd_sequencer #(.DATA_W(8), .SYNC_STAGES(S), .CASCADE_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    pic_cmd_sequencer #(.DATA_W(8), .SYNC_STAGES(S), .CASCADE_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    int   lat_a, err_a, lat_b, err_b;
    logic oe_seen;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds wr_n low long enough to be captured, releases it, then watches both DUTs.
    task automatic do_write(input logic a0v, input logic [7:0] dv, input logic csv, input logic rdv);
        oe_seen   = 1'b0;
        bus.cs_n  = csv;
        bus.a0    = a0v;
        bus.d_in  = dv;
        bus.rd_n  = rdv;
        bus.wr_n  = 1'b0;
        repeat (S + 2) begin
            step();
            if (bus.d_oe) oe_seen = 1'b1;
        end
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        lat_a = 0; err_a = 0; lat_b = 0; err_b = 0;
        for (int k = 1; k <= S + 3; k++) begin
            step();
            if (bus.d_oe) oe_seen = 1'b1;
            if (bus.cmd_valid && lat_a == 0) lat_a = k;
            if (bus_b.cmd_valid && lat_b == 0) lat_b = k;
            if (bus.seq_err) err_a++;
            if (bus_b.seq_err) err_b++;
        end
        bus.cs_n = 1'b1;
    endtask

    task automatic wr_ok(input string tag, input logic a0v, input logic [7:0] dv,
                         input logic typ, input logic [1:0] nr);
        do_write(a0v, dv, 1'b0, 1'b1);
        check({tag, "_lat"}, lat_a, S + 1);
        check({tag, "_err"}, err_a, 0);
        check({tag, "_cmd"}, {bus.cmd_type, bus.cmd_nr, bus.cmd_data}, {typ, nr, dv});
    endtask

    task automatic do_read(input string tag, input logic a0v, input logic [7:0] exp_d);
        bus.cs_n = 1'b0;
        bus.a0   = a0v;
        bus.rd_n = 1'b0;
        repeat (S) step();
        check({tag, "_oe_early"}, bus.d_oe, 0);
        step();
        check({tag, "_oe"}, bus.d_oe, 1);
        check({tag, "_dout"}, bus.d_out, exp_d);
        bus.rd_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (S + 2) step();
        check({tag, "_dout_idle"}, {bus.d_oe, bus.d_out}, 0);
    endtask

    function automatic logic [31:0] out_vec();
        return {bus.cmd_valid, bus.cmd_type, bus.cmd_nr, bus.cmd_data,
                bus.init_done, bus.seq_err, bus.d_oe, bus.d_out};
    endfunction

    int vld_cnt;

    initial begin
        rst_n    = 1'b0;
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.a0   = 1'b0;
        bus.d_in = 8'h00;
        bus.irr  = 8'h11;
        bus.isr  = 8'h80;
        bus.imr  = 8'h5A;
        repeat (3) step();
        check("reset_outputs", out_vec(), 0);
        rst_n = 1'b1;
        repeat (2) step();

        do_write(1'b0, 8'h20, 1'b0, 1'b1);
        check("uninit_drop_vld", lat_a, 0);
        check("uninit_drop_err", err_a, 1);

        wr_ok("icw1_13", 1'b0, 8'h13, 1'b1, 2'd0);
        wr_ok("icw2_20", 1'b1, 8'h20, 1'b1, 2'd1);
        check("init_after_icw2", bus.init_done, 0);
        wr_ok("icw4_01", 1'b1, 8'h01, 1'b1, 2'd3);
        check("init_after_icw4", bus.init_done, 1);

        wr_ok("ocw3_0b", 1'b0, 8'h0B, 1'b0, 2'd2);
        do_read("rd_isr", 1'b0, 8'h80);
        wr_ok("ocw3_0a", 1'b0, 8'h0A, 1'b0, 2'd2);
        do_read("rd_irr", 1'b0, 8'h11);
        do_read("rd_imr", 1'b1, 8'h5A);
        wr_ok("ocw2_20", 1'b0, 8'h20, 1'b0, 2'd1);

        do_write(1'b1, 8'hFF, 1'b0, 1'b0);
        check("rdwr_lat", lat_a, S + 1);
        check("rdwr_cmd", {bus.cmd_type, bus.cmd_nr, bus.cmd_data}, {1'b0, 2'd0, 8'hFF});
        check("rdwr_oe", oe_seen, 0);

        do_write(1'b1, 8'h33, 1'b1, 1'b1);
        check("csn_hi_vld", lat_a, 0);
        check("csn_hi_err", err_a, 0);
        check("csn_hi_data", bus.cmd_data, 8'hFF);

        wr_ok("casc_icw1", 1'b0, 8'h10, 1'b1, 2'd0);
        check("b_icw1", {lat_b, 1'b0, bus_b.cmd_type, bus_b.cmd_nr}, {S + 1, 1'b0, 1'b1, 2'd0});
        do_write(1'b0, 8'h20, 1'b0, 1'b1);
        check("wait2_drop", {lat_a, err_a}, {32'd0, 32'd1});
        check("b_wait2_drop", {lat_b, err_b}, {32'd0, 32'd1});
        wr_ok("casc_icw2", 1'b1, 8'h08, 1'b1, 2'd1);
        check("b_icw2", {bus_b.cmd_type, bus_b.cmd_nr, bus_b.init_done}, {1'b1, 2'd1, 1'b1});
        check("a_init_wait3", bus.init_done, 0);
        wr_ok("casc_icw3", 1'b1, 8'h04, 1'b1, 2'd2);
        check("a_init_ready", bus.init_done, 1);
        check("b_ocw1", {lat_b, 1'b0, bus_b.cmd_type, bus_b.cmd_nr, bus_b.cmd_data},
              {S + 1, 1'b0, 1'b0, 2'd0, 8'h04});

        wr_ok("sel_isr", 1'b0, 8'h0B, 1'b0, 2'd2);
        wr_ok("re_icw1", 1'b0, 8'h10, 1'b1, 2'd0);
        wr_ok("re_icw2", 1'b1, 8'h08, 1'b1, 2'd1);
        wr_ok("restart_icw1", 1'b0, 8'h17, 1'b1, 2'd0);
        do_read("restart_irr", 1'b0, 8'h11);
        wr_ok("restart_icw2", 1'b1, 8'h08, 1'b1, 2'd1);
        check("wait4_init", bus.init_done, 0);

        bus.cs_n = 1'b0;
        bus.a0   = 1'b1;
        bus.d_in = 8'h01;
        bus.wr_n = 1'b0;
        repeat (S + 2) step();
        bus.wr_n = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", out_vec(), 0);
        step();
        rst_n   = 1'b1;
        vld_cnt = 0;
        repeat (S + 3) begin
            step();
            if (bus.cmd_valid) vld_cnt++;
        end
        bus.cs_n = 1'b1;
        check("pending_discard", vld_cnt, 0);

        do_write(1'b1, 8'h01, 1'b0, 1'b1);
        check("post_reset_uninit", {lat_a, err_a}, {32'd0, 32'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
